prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter IDLE_TIMEOUT, default 50000; the number of clk cycles without an accepted byte mid-frame before an abort.
REQ-002 SHALL have port clk  input  1  system clock, rising-edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port rx_valid  input  1  host byte available.
REQ-005 SHALL have port rx_byte  input  8  host byte.
REQ-006 SHALL have port rx_ready  output  1  loader can accept a byte; transfer occurs on a clk edge when rx_valid && rx_ready.
REQ-007 SHALL have port mem_we  output  1  program-memory write strobe, one cycle per byte.
REQ-008 SHALL have port mem_addr  output  12  program-memory write address.
REQ-009 SHALL have port mem_wdata  output  8  program-memory write data.
REQ-010 SHALL have port cpu_hold  output  1  holds the processor in reset while high.
REQ-011 SHALL have port done  output  1  one-cycle pulse on successful load.
REQ-012 SHALL have port err  output  1  level, load failed.

Function
REQ-013 SHALL implement FSM states IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERROR.
REQ-014 SHALL drive rx_ready=1 in every state except DONE.
REQ-015 SHALL, in IDLE, advance to LEN_HI on an accepted 0xA5 and discard every other byte; cpu_hold=0 in IDLE.
REQ-016 SHALL, in LEN_HI, latch len[11:8]=rx_byte[3:0]; rx_byte[7:4]!=0 SHALL go to ERROR.
REQ-017 SHALL, in LEN_LO, latch len[7:0], clear address and checksum to 0, and go to DATA; a frame carries len+1 data bytes (1..4096).
REQ-018 SHALL hold cpu_hold=1 in LEN_HI, LEN_LO, DATA, CHECK and ERROR.
REQ-019 SHALL, per accepted DATA byte, assert mem_we for exactly the following cycle with mem_addr = current address and mem_wdata = that byte (latency 1), then increment the address and add the byte to an 8-bit modulo-256 sum.
REQ-020 SHALL leave DATA after byte number len+1; address 4095 SHALL be the final byte and never wrap within a frame.
REQ-021 SHALL keep mem_we=0 in every state other than the cycle following a DATA accept.
REQ-022 SHALL, in CHECK, go to DONE if (sum + rx_byte) mod 256 == 0, else ERROR.
REQ-023 SHALL, in DONE, pulse done=1 for one cycle, drive cpu_hold=0, and return to IDLE on the next cycle.
REQ-024 SHALL, in ERROR, hold err=1; an accepted 0xA5 SHALL clear err and go to LEN_HI; all other bytes are discarded.
REQ-025 SHALL count cycles since the last accepted byte in LEN_HI/LEN_LO/DATA/CHECK, clear the count on each accept, and go to ERROR when it reaches IDLE_TIMEOUT; a byte accepted on that same cycle takes priority.
REQ-026 SHALL treat 0xA5 received inside a frame as ordinary data, not as a restart.

Reset
REQ-027 SHALL, on rst, enter IDLE asynchronously with rx_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, done=0, err=0, sum=0, len=0 and timeout count=0.
REQ-028 SHALL, on rst asserted mid-frame, abandon the frame with no further writes; memory contents already written are not restored.

Configuration
REQ-029 SHALL, with PROG_LOADER_CHECKSUM_EN defined, include the CHECK state and the checksum byte as in REQ-022.
REQ-030 SHALL, without PROG_LOADER_CHECKSUM_EN, omit the sum logic and CHECK, and go from the last DATA byte directly to DONE; a checksum byte sent after the frame is then discarded in IDLE.

Verification
REQ-031 SHALL cover: A5,00,02,10,20,30,A0 with CHECKSUM_EN -> writes 10@0,20@1,30@2; done pulse; err=0; cpu_hold high from the A5 accept until DONE.
REQ-032 SHALL cover: same frame with checksum 0xA1 -> three writes performed, err=1, cpu_hold stays 1, no done; then a valid frame -> err clears and done pulses.
REQ-033 SHALL cover: A5,0F,FF,4096 bytes of address[7:0], matching checksum -> last write at address 0xFFF, no write at 0x000 after the first, done pulses.
REQ-034 SHALL cover: A5,10 -> ERROR from the length check, no mem_we asserted.
REQ-035 SHALL cover: IDLE_TIMEOUT=20; A5,00,05,11 then rx_valid low for 20 cycles -> err=1 and exactly one write (11@0).
REQ-036 SHALL cover: rst asserted after the second DATA byte of a 5-byte frame -> all outputs immediately at reset values and no further mem_we.

Source files
------------

// File: rtl/prog_loader.sv
// Serial program loader: receives an A5-framed byte stream, writes it into program memory
// and holds the CPU in reset meanwhile. Define PROG_LOADER_CHECKSUM_EN to require a trailing checksum byte.
module prog_loader #(
  parameter int IDLE_TIMEOUT = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [11:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  localparam int TW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(IDLE_TIMEOUT - 1);
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
`ifdef PROG_LOADER_CHECKSUM_EN
    ST_CHECK,
`endif
    ST_DONE,
    ST_ERROR
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [11:0]   r_len;
  logic [11:0]   r_addr;
  logic [TW-1:0] r_timer;
  logic          r_rx_ready;
  logic          r_mem_we;
  logic [11:0]   r_mem_addr;
  logic [7:0]    r_mem_wdata;
  logic          r_cpu_hold;
  logic          r_done;
  logic          r_err;

  logic w_accept;
  logic w_in_frame;
  logic w_timeout;
  logic w_data_accept;
  logic w_last_data;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] r_sum;
  logic [7:0] w_sum_total;
  assign w_sum_total = r_sum + rx_byte;
`endif

  assign w_accept      = rx_valid & r_rx_ready;
  assign w_data_accept = w_accept && (r_state == ST_DATA);
  // The frame carries len+1 bytes, so the byte landing at address len is the last one.
  assign w_last_data   = (r_addr == r_len);

`ifdef PROG_LOADER_CHECKSUM_EN
  assign w_in_frame = (r_state == ST_LEN_HI) || (r_state == ST_LEN_LO) ||
                      (r_state == ST_DATA)   || (r_state == ST_CHECK);
`else
  assign w_in_frame = (r_state == ST_LEN_HI) || (r_state == ST_LEN_LO) ||
                      (r_state == ST_DATA);
`endif

  // An accept on the expiry cycle wins over the abort.
  assign w_timeout = w_in_frame && !w_accept && (r_timer == TIMER_LAST);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && (rx_byte == SYNC_BYTE)) w_state_next = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (w_accept)       w_state_next = (rx_byte[7:4] != 4'h0) ? ST_ERROR : ST_LEN_LO;
        else if (w_timeout) w_state_next = ST_ERROR;
      end
      ST_LEN_LO: begin
        if (w_accept)       w_state_next = ST_DATA;
        else if (w_timeout) w_state_next = ST_ERROR;
      end
      ST_DATA: begin
        if (w_accept) begin
          if (w_last_data) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            w_state_next = ST_CHECK;
`else
            w_state_next = ST_DONE;
`endif
          end
        end else if (w_timeout) begin
          w_state_next = ST_ERROR;
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (w_accept)       w_state_next = (w_sum_total == 8'h00) ? ST_DONE : ST_ERROR;
        else if (w_timeout) w_state_next = ST_ERROR;
      end
`endif
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      ST_ERROR: begin
        if (w_accept && (rx_byte == SYNC_BYTE)) w_state_next = ST_LEN_HI;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_len       <= '0;
      r_addr      <= '0;
      r_timer     <= '0;
      r_rx_ready  <= 1'b1;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_hold  <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      r_sum       <= '0;
`endif
    end else begin
      r_state    <= w_state_next;
      r_rx_ready <= (w_state_next != ST_DONE);
      r_cpu_hold <= (w_state_next != ST_IDLE) && (w_state_next != ST_DONE);
      r_done     <= (w_state_next == ST_DONE);
      r_err      <= (w_state_next == ST_ERROR);
      r_mem_we   <= w_data_accept;

      if (w_in_frame && !w_accept && !w_timeout) r_timer <= r_timer + TW'(1);
      else                                      r_timer <= '0;

      if (w_accept && (r_state == ST_LEN_HI)) r_len[11:8] <= rx_byte[3:0];

      if (w_accept && (r_state == ST_LEN_LO)) begin
        r_len[7:0] <= rx_byte;
        r_addr     <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
        r_sum      <= '0;
`endif
      end

      if (w_data_accept) begin
        r_mem_addr  <= r_addr;
        r_mem_wdata <= rx_byte;
        r_addr      <= r_addr + 12'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
        r_sum       <= w_sum_total;
`endif
      end
    end
  end

  assign rx_ready  = r_rx_ready;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign cpu_hold  = r_cpu_hold;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader; expectations adapt to whether PROG_LOADER_CHECKSUM_EN is defined.
module tb_prog_loader;

  localparam int TIMEOUT = 20;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_byte  = 8'h00;
  logic        rx_ready;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int checks   = 0;
  int failures = 0;

  int          wr_count     = 0;
  int          done_count   = 0;
  int          wr_at_zero   = 0;
  logic [11:0] last_wr_addr = '0;
  logic [7:0]  tb_mem [4096];

  prog_loader #(.IDLE_TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_byte   (rx_byte),
    .rx_ready  (rx_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Memory-side observer: records every write strobe and done pulse seen before each edge.
  always @(posedge clk) begin
    if (mem_we) begin
      wr_count          <= wr_count + 1;
      last_wr_addr      <= mem_addr;
      tb_mem[mem_addr]  <= mem_wdata;
      if (mem_addr == 12'h000) wr_at_zero <= wr_at_zero + 1;
    end
    if (done) done_count <= done_count + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Present a byte just after a falling edge; returns at the falling edge after it is accepted.
  task automatic send(input logic [7:0] b);
    int waited;
    waited   = 0;
    rx_valid = 1'b1;
    rx_byte  = b;
    while (rx_ready !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 40) begin
      checks++;
      failures++;
      $display("FAIL send_wait: rx_ready=%b after %0d cycles, required 1", rx_ready, waited);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_header(input logic [11:0] len);
    send(8'hA5);
    send({4'h0, len[11:8]});
    send(len[7:0]);
  endtask

  task automatic send_data(input logic [7:0] b, input logic [11:0] a);
    send(b);
    checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, a, b}) begin
      failures++;
      $display("FAIL data_write: we=%b addr=%h data=%h, required we=1 addr=%h data=%h",
               mem_we, mem_addr, mem_wdata, a, b);
    end
  endtask

  task automatic finish_frame(input logic [7:0] cs, input logic exp_ok, input string name);
`ifdef PROG_LOADER_CHECKSUM_EN
    checks++;
    if ({cpu_hold, done, err} !== 3'b100) begin
      failures++;
      $display("FAIL %s_check_state: hold/done/err=%b, required 100", name, {cpu_hold, done, err});
    end
    send(cs);
    checks++;
    if ({rx_ready, cpu_hold, done, err} !== (exp_ok ? 4'b0010 : 4'b1101)) begin
      failures++;
      $display("FAIL %s_outcome: ready/hold/done/err=%b, required %b", name,
               {rx_ready, cpu_hold, done, err}, (exp_ok ? 4'b0010 : 4'b1101));
    end
    if (exp_ok) begin
      @(negedge clk);
      checks++;
      if ({rx_ready, cpu_hold, done} !== 3'b100) begin
        failures++;
        $display("FAIL %s_back_to_idle: ready/hold/done=%b, required 100", name, {rx_ready, cpu_hold, done});
      end
    end
    $display("frame %s: checksum %h, %s", name, cs, exp_ok ? "load complete" : "load rejected");
`else
    checks++;
    if ({rx_ready, cpu_hold, done, err} !== 4'b0010) begin
      failures++;
      $display("FAIL %s_outcome: ready/hold/done/err=%b, required 0010", name, {rx_ready, cpu_hold, done, err});
    end
    send(cs);
    checks++;
    if ({rx_ready, cpu_hold, done, err, mem_we} !== 5'b10000) begin
      failures++;
      $display("FAIL %s_trailer_discarded: ready/hold/done/err/we=%b, required 10000", name,
               {rx_ready, cpu_hold, done, err, mem_we});
    end
    $display("frame %s: load complete, trailing byte %h (%s checksum) discarded", name, cs,
             exp_ok ? "good" : "bad");
`endif
  endtask

  task automatic test_reset;
    rst      = 1'b1;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({rx_ready, mem_we, cpu_hold, done, err} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_ctrl: ready/we/hold/done/err=%b, required 10000", {rx_ready, mem_we, cpu_hold, done, err});
    end
    checks++;
    if ({mem_addr, mem_wdata} !== 20'h00000) begin
      failures++;
      $display("FAIL reset_bus: addr=%h data=%h, required 000/00", mem_addr, mem_wdata);
    end
    rst = 1'b0;
    @(negedge clk);
    send(8'h11);
    checks++;
    if ({cpu_hold, mem_we, err} !== 3'b000) begin
      failures++;
      $display("FAIL idle_discard: hold/we/err=%b, required 000", {cpu_hold, mem_we, err});
    end
    $display("reset: outputs at reset values, non-sync byte discarded in idle");
  endtask

  task automatic test_basic;
    logic [7:0] d [3];
    int wr0, dn0;
    d[0] = 8'h10; d[1] = 8'h20; d[2] = 8'h30;
    wr0 = wr_count;
    dn0 = done_count;
    send(8'hA5);
    checks++;
    if ({cpu_hold, err, mem_we} !== 3'b100) begin
      failures++;
      $display("FAIL basic_hold_after_sync: hold/err/we=%b, required 100", {cpu_hold, err, mem_we});
    end
    send(8'h00);
    send(8'h02);
    checks++;
    if ({cpu_hold, mem_we} !== 2'b10) begin
      failures++;
      $display("FAIL basic_hold_len: hold/we=%b, required 10", {cpu_hold, mem_we});
    end
    for (int i = 0; i < 3; i++) send_data(d[i], 12'(i));
    finish_frame(8'hA0, 1'b1, "basic");
    @(negedge clk);
    checks++;
    if (wr_count - wr0 !== 3) begin
      failures++;
      $display("FAIL basic_write_count: got %0d, required 3", wr_count - wr0);
    end
    checks++;
    if (done_count - dn0 !== 1) begin
      failures++;
      $display("FAIL basic_done_count: got %0d, required 1", done_count - dn0);
    end
    checks++;
    if ({tb_mem[0], tb_mem[1], tb_mem[2]} !== 24'h102030) begin
      failures++;
      $display("FAIL basic_mem: got %h, required 102030", {tb_mem[0], tb_mem[1], tb_mem[2]});
    end
  endtask

  task automatic test_bad_checksum;
    int wr0, dn0;
    wr0 = wr_count;
    dn0 = done_count;
    send_header(12'h002);
    send_data(8'h10, 12'h000);
    send_data(8'h20, 12'h001);
    send_data(8'h30, 12'h002);
    finish_frame(8'hA1, 1'b0, "bad_sum");
    @(negedge clk);
    checks++;
    if (wr_count - wr0 !== 3) begin
      failures++;
      $display("FAIL bad_sum_write_count: got %0d, required 3", wr_count - wr0);
    end
    checks++;
    if (done_count - dn0 !== (CS_EN ? 0 : 1)) begin
      failures++;
      $display("FAIL bad_sum_done_count: got %0d, required %0d", done_count - dn0, (CS_EN ? 0 : 1));
    end
    checks++;
    if ({cpu_hold, err} !== (CS_EN ? 2'b11 : 2'b00)) begin
      failures++;
      $display("FAIL bad_sum_state: hold/err=%b, required %b", {cpu_hold, err}, (CS_EN ? 2'b11 : 2'b00));
    end
    dn0 = done_count;
    send(8'hA5);
    checks++;
    if ({cpu_hold, err} !== 2'b10) begin
      failures++;
      $display("FAIL bad_sum_recover_sync: hold/err=%b, required 10", {cpu_hold, err});
    end
    send(8'h00);
    send(8'h00);
    send_data(8'h42, 12'h000);
    finish_frame(8'hBE, 1'b1, "recover");
    @(negedge clk);
    checks++;
    if (done_count - dn0 !== 1) begin
      failures++;
      $display("FAIL recover_done_count: got %0d, required 1", done_count - dn0);
    end
  endtask

  task automatic test_len_error;
    int wr0;
    wr0 = wr_count;
    send(8'hA5);
    send(8'h10);
    checks++;
    if ({cpu_hold, err, mem_we} !== 3'b110) begin
      failures++;
      $display("FAIL len_error_state: hold/err/we=%b, required 110", {cpu_hold, err, mem_we});
    end
    repeat (TIMEOUT + 5) @(negedge clk);
    send(8'h33);
    checks++;
    if ({cpu_hold, err} !== 2'b11) begin
      failures++;
      $display("FAIL error_discard: hold/err=%b, required 11", {cpu_hold, err});
    end
    checks++;
    if (wr_count - wr0 !== 0) begin
      failures++;
      $display("FAIL len_error_writes: got %0d, required 0", wr_count - wr0);
    end
    $display("length error: err latched, stray byte discarded");
    send(8'hA5);
    checks++;
    if ({cpu_hold, err} !== 2'b10) begin
      failures++;
      $display("FAIL len_error_recover: hold/err=%b, required 10", {cpu_hold, err});
    end
    send(8'h00);
    send(8'h00);
    send_data(8'h77, 12'h000);
    finish_frame(8'h89, 1'b1, "after_len_error");
  endtask

  task automatic test_back_to_back;
    int wr0, dn0;
    wr0 = wr_count;
    dn0 = done_count;
    send_header(12'h001);
    send_data(8'hA5, 12'h000);
    send_data(8'h5B, 12'h001);
    finish_frame(8'h00, 1'b1, "a5_as_data");
    send_header(12'h000);
    send_data(8'hC3, 12'h000);
    finish_frame(8'h3D, 1'b1, "second");
    @(negedge clk);
    checks++;
    if (wr_count - wr0 !== 3) begin
      failures++;
      $display("FAIL b2b_write_count: got %0d, required 3", wr_count - wr0);
    end
    checks++;
    if (done_count - dn0 !== 2) begin
      failures++;
      $display("FAIL b2b_done_count: got %0d, required 2", done_count - dn0);
    end
    checks++;
    if ({tb_mem[0], tb_mem[1]} !== 16'hC35B) begin
      failures++;
      $display("FAIL b2b_mem: got %h, required c35b", {tb_mem[0], tb_mem[1]});
    end
  endtask

  task automatic test_timeout;
    int wr0;
    wr0 = wr_count;
    send_header(12'h005);
    send_data(8'h11, 12'h000);
    repeat (TIMEOUT - 1) @(negedge clk);
    checks++;
    if ({cpu_hold, err} !== 2'b10) begin
      failures++;
      $display("FAIL timeout_early: hold/err=%b after %0d idle cycles, required 10", {cpu_hold, err}, TIMEOUT - 1);
    end
    @(negedge clk);
    checks++;
    if ({cpu_hold, err} !== 2'b11) begin
      failures++;
      $display("FAIL timeout_fired: hold/err=%b after %0d idle cycles, required 11", {cpu_hold, err}, TIMEOUT);
    end
    @(negedge clk);
    checks++;
    if (wr_count - wr0 !== 1) begin
      failures++;
      $display("FAIL timeout_writes: got %0d, required 1", wr_count - wr0);
    end
    $display("timeout: frame aborted after %0d idle cycles", TIMEOUT);
  endtask

  task automatic test_full_frame;
    int wr0, dn0, z0, bad;
    wr0 = wr_count;
    dn0 = done_count;
    z0  = wr_at_zero;
    bad = 0;
    send_header(12'hFFF);
    for (int i = 0; i < 4096; i++) begin
      send(i[7:0]);
      if (mem_we !== 1'b1 || mem_addr !== 12'(i) || mem_wdata !== i[7:0]) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL full_data_writes: %0d bad write strobes, required 0", bad);
    end
    finish_frame(8'h00, 1'b1, "full_4096");
    @(negedge clk);
    checks++;
    if (wr_count - wr0 !== 4096) begin
      failures++;
      $display("FAIL full_write_count: got %0d, required 4096", wr_count - wr0);
    end
    checks++;
    if (last_wr_addr !== 12'hFFF) begin
      failures++;
      $display("FAIL full_last_addr: got %h, required fff", last_wr_addr);
    end
    checks++;
    if (wr_at_zero - z0 !== 1) begin
      failures++;
      $display("FAIL full_addr_zero_writes: got %0d, required 1", wr_at_zero - z0);
    end
    checks++;
    if (tb_mem[12'hABC] !== 8'hBC) begin
      failures++;
      $display("FAIL full_mem_sample: got %h, required bc", tb_mem[12'hABC]);
    end
    checks++;
    if (done_count - dn0 !== 1) begin
      failures++;
      $display("FAIL full_done_count: got %0d, required 1", done_count - dn0);
    end
  endtask

  task automatic test_reset_midframe;
    int wr1;
    send_header(12'h004);
    send_data(8'h01, 12'h000);
    send_data(8'h02, 12'h001);
    rx_valid = 1'b1;
    rx_byte  = 8'h03;
    #2 rst = 1'b1;
    #1;
    wr1 = wr_count;
    checks++;
    if ({rx_ready, mem_we, cpu_hold, done, err} !== 5'b10000) begin
      failures++;
      $display("FAIL midframe_reset_ctrl: ready/we/hold/done/err=%b, required 10000",
               {rx_ready, mem_we, cpu_hold, done, err});
    end
    checks++;
    if ({mem_addr, mem_wdata} !== 20'h00000) begin
      failures++;
      $display("FAIL midframe_reset_bus: addr=%h data=%h, required 000/00", mem_addr, mem_wdata);
    end
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send(8'h04);
    repeat (3) @(negedge clk);
    checks++;
    if (wr_count !== wr1) begin
      failures++;
      $display("FAIL midframe_no_writes: %0d writes after reset, required 0", wr_count - wr1);
    end
    checks++;
    if ({cpu_hold, err, done} !== 3'b000) begin
      failures++;
      $display("FAIL midframe_idle: hold/err/done=%b, required 000", {cpu_hold, err, done});
    end
    $display("reset mid-frame: frame abandoned, no further writes");
  endtask

  initial begin
    test_reset;
    test_basic;
    test_bad_checksum;
    test_len_error;
    test_back_to_back;
    test_timeout;
    test_full_frame;
    test_reset_midframe;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
